// File: rtl/cnn_stream_pkg.sv
// Shared defaults and types for the CNN feature-map streaming blocks.
// Geometry matches the conv1 output / conv2 input feature maps.
package cnn_stream_pkg;

    localparam int CNN_DATA_WIDTH = 24;
    localparam int CNN_IMG_W      = 14;
    localparam int CNN_IMG_H      = 14;
    localparam int CNN_NUM_CH     = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } src_state_t;

endpackage

// File: rtl/fmap_buffer_ram.sv
// Simple dual-port single-clock frame buffer with a registered read port.
// Only the read register is reset; the array itself is left uninitialised.
module fmap_buffer_ram #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH      = 1176,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fmap_stream_source.sv
// Buffers a multi-channel feature map and replays it channel-major,
// raster order, as a continuous valid-qualified pixel stream.
module fmap_stream_source
    import cnn_stream_pkg::*;
#(
    parameter int DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int IMG_W      = CNN_IMG_W,
    parameter int IMG_H      = CNN_IMG_H,
    parameter int NUM_CH     = CNN_NUM_CH,
    parameter int DEPTH      = NUM_CH * IMG_W * IMG_H,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_drop,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [2:0]            ch_idx,
    output logic                  last_pix,
    output logic                  last_all,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0]         COL_MAX  = CW'(IMG_W - 1);
    localparam logic [RW-1:0]         ROW_MAX  = RW'(IMG_H - 1);
    localparam logic [2:0]            CH_MAX   = 3'(NUM_CH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(DEPTH - 1);

    src_state_t            state;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [2:0]            ch;

    logic rd_en;
    logic col_end;
    logic row_end;
    logic addr_end;
    logic wr_ok;
    logic ram_we;

    assign rd_en    = (state == STREAM);
    assign col_end  = (col == COL_MAX);
    assign row_end  = (row == ROW_MAX);
    assign addr_end = (rd_addr == ADDR_MAX);
    assign busy     = (state != IDLE);

    // Loads only land while idle, so a running replay never sees torn data.
    assign wr_ok   = (state == IDLE) && (wr_addr <= ADDR_MAX);
    assign ram_we  = wr_en && wr_ok;
    assign wr_drop = wr_en && !wr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_addr   <= '0;
            col       <= '0;
            row       <= '0;
            ch        <= '0;
            valid_out <= 1'b0;
            ch_idx    <= '0;
            last_pix  <= 1'b0;
            last_all  <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Sideband lags the read address by one cycle to meet RAM data.
            valid_out <= rd_en;
            ch_idx    <= ch;
            last_pix  <= rd_en && col_end && row_end;
            last_all  <= rd_en && col_end && row_end && (ch == CH_MAX);
            done      <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= STREAM;
                        rd_addr <= '0;
                        col     <= '0;
                        row     <= '0;
                        ch      <= '0;
                    end
                end
                STREAM: begin
                    rd_addr <= addr_end ? '0 : rd_addr + 1'b1;
                    if (col_end) begin
                        col <= '0;
                        if (row_end) begin
                            row <= '0;
                            ch  <= addr_end ? '0 : ch + 1'b1;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end else begin
                        col <= col + 1'b1;
                    end
                    if (addr_end) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    fmap_buffer_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (data_out)
    );

endmodule

// File: doc/fmap_stream_source.md
# fmap_stream_source

Streaming source that buffers the six input feature-map channels produced by the previous layer and replays them, channel-major and raster order, as a `data_out`/`valid_out` pixel stream. The stream feeds the conv2 feature-map blocks' `data_in`/`valid_in` ports. Loading uses a simple write port; replay starts on a one-cycle `start` pulse and ends with a `done` pulse.

## Interface
- `DATA_WIDTH`, 24: pixel width, two's-complement fixed point, passed through unmodified.
- `IMG_W`, 14: pixels per line.
- `IMG_H`, 14: lines per channel.
- `NUM_CH`, 6: channels per frame.
- `DEPTH`, `NUM_CH*IMG_W*IMG_H` (1176): buffer words, derived.
- `ADDR_WIDTH`, `$clog2(DEPTH)` (11): address width, derived.

Ports:
- `clk`  in  1: single clock; all logic rises on the posedge.
- `rst`  in  1: synchronous, active-high reset.
- `wr_en`  in  1: load strobe.
- `wr_addr`  in  ADDR_WIDTH: load address, `ch*IMG_W*IMG_H + row*IMG_W + col`.
- `wr_data`  in  DATA_WIDTH: load pixel.
- `wr_drop`  out  1: pulses when a write is rejected.
- `start`  in  1: begin replay; sampled only in IDLE.
- `data_out`  out  DATA_WIDTH: streamed pixel.
- `valid_out`  out  1: `data_out` qualifier.
- `ch_idx`  out  3: channel of the current pixel.
- `last_pix`  out  1: last pixel of the current channel.
- `last_all`  out  1: last pixel of the frame.
- `busy`  out  1: replay in progress.
- `done`  out  1: one-cycle completion pulse.

## Operation
- **FSM states:** IDLE, STREAM, FLUSH.
- **IDLE → STREAM:** on `start`=1. The read counter clears to 0.
- **STREAM:** one read per cycle, `rd_addr` 0..DEPTH-1. Column, row and channel counters advance with `rd_addr`: column wraps at IMG_W-1, row wraps at IMG_H-1, then the channel increments.
  - When `rd_addr`=DEPTH-1 is issued, the FSM goes to FLUSH.
- **FLUSH:** lasts one cycle. The last pixel leaves the RAM output register, then the FSM returns to IDLE. `done`=1 in the cycle after the last `valid_out`.
- **Sideband alignment:** `valid_out`, `ch_idx`, `last_pix` and `last_all` are the read-side sideband delayed one cycle, so they align with RAM read data.
- **Writes:**
  - Writes are accepted only in IDLE.
  - `wr_en` in STREAM or FLUSH is dropped, memory is unchanged, and `wr_drop`=1 for that cycle.
  - `wr_addr` ≥ DEPTH is dropped the same way in any state.
- **`start` outside IDLE:** ignored, with no restart or queuing.
- **Simultaneous `start` and `wr_en` in IDLE:** the write is performed. Replay begins next cycle and reads the updated word.
- **Data integrity:** no arithmetic; data is bit-exact, sign preserved.

## Timing
- **Reset values:**
  - `data_out`=0, `valid_out`=0, `ch_idx`=0, `last_pix`=0, `last_all`=0, `busy`=0, `done`=0, `wr_drop`=0.
  - State is IDLE and all counters are 0.
  - Buffer contents are not reset.
- **Latency:** with `start` high in cycle 0, `busy`=1 from cycle 1. First `valid_out` is in cycle 2; the last is in cycle DEPTH+1 (1177).
- **`busy` and `done`:** `busy` falls after cycle DEPTH+1. `done`=1 in cycle DEPTH+2.
- **Stream shape:** `valid_out` is continuous with no bubbles, DEPTH cycles long. There is no back-pressure, because downstream conv blocks accept every cycle.
- **Reset mid-stream:** `rst` sampled high at any edge gives reset values at that edge. No `done` is issued, and the next `start` replays from address 0.
- **Back-to-back replays:** earliest `start` is in the `done` cycle, when the FSM is already in IDLE. First `valid_out` follows 2 cycles later.

## Structure
- **Package `cnn_stream_pkg`:** `DATA_WIDTH`, `IMG_W`, `IMG_H`, `NUM_CH` defaults, and the `src_state_t` enum (IDLE/STREAM/FLUSH).
- **Sub-module `fmap_buffer_ram`:** simple dual-port single-clock RAM, DEPTH×DATA_WIDTH, with registered read and 1-cycle latency. It holds no reset on the data array.
- **Top level:** the FSM, counters, sideband delay register and write-guard logic.

## Test plan
- **Ramp replay:** load `mem[a]=a` for a=0..1175, pulse `start` in cycle 0.
  - `valid_out` high in cycles 2..1177 with `data_out`=0..1175 in order.
  - `done`=1 only in cycle 1178.
- **Sideband:** with the same frame, `ch_idx` steps 0→5 at stream offsets 196, 392, …, 980.
  - `last_pix`=1 at offsets 195, 391, …, 1175.
  - `last_all`=1 only at offset 1175.
- **Sign preservation:** load `mem[0]`=24'hFFFFFF and `mem[1]`=24'h800000. First two outputs are exactly those values.
- **Write guard:**
  - `wr_en` at address 10 with value 24'h123456 during STREAM gives `wr_drop`=1 for that cycle, and a subsequent replay still outputs 10 at offset 10.
  - `wr_addr`=1200 in IDLE gives `wr_drop`=1.
- **`start` while busy:** a pulse at stream offset 300 produces no restart. Exactly 1176 valid cycles and one `done`.
- **Reset mid-stream:** `rst` at offset 500 drops all outputs to 0 in the same edge and gives no `done`. A new `start` replays from `data_out`=0 with the full 1176 pixels.
